// File: rtl/alu_exec_unit_pkg.sv
// Shared widths, function codes and execute-state encoding for the 16-bit
// execute stage.
package alu_exec_unit_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int FUNC_WIDTH  = 4;
  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH) + 1;

  localparam logic [FUNC_WIDTH-1:0] FUNC_SET = 4'd0;
  localparam logic [FUNC_WIDTH-1:0] FUNC_ADD = 4'd1;
  localparam logic [FUNC_WIDTH-1:0] FUNC_SUB = 4'd2;
  localparam logic [FUNC_WIDTH-1:0] FUNC_AND = 4'd3;
  localparam logic [FUNC_WIDTH-1:0] FUNC_OR  = 4'd4;
  localparam logic [FUNC_WIDTH-1:0] FUNC_XOR = 4'd5;
  localparam logic [FUNC_WIDTH-1:0] FUNC_NOT = 4'd6;
  localparam logic [FUNC_WIDTH-1:0] FUNC_LSS = 4'd7;
  localparam logic [FUNC_WIDTH-1:0] FUNC_EQL = 4'd8;
  localparam logic [FUNC_WIDTH-1:0] FUNC_GRT = 4'd9;
  localparam logic [FUNC_WIDTH-1:0] FUNC_ULS = 4'd10;
  localparam logic [FUNC_WIDTH-1:0] FUNC_URS = 4'd11;
  localparam logic [FUNC_WIDTH-1:0] FUNC_SLS = 4'd12;
  localparam logic [FUNC_WIDTH-1:0] FUNC_SRS = 4'd13;
  localparam logic [FUNC_WIDTH-1:0] FUNC_ABS = 4'd14;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} exec_state_t;

  function automatic logic is_shift(input logic [FUNC_WIDTH-1:0] f);
    return (f == FUNC_ULS) || (f == FUNC_URS) || (f == FUNC_SLS) || (f == FUNC_SRS);
  endfunction

endpackage

// File: rtl/alu_exec_unit_alu.sv
// Combinational arithmetic/logic unit for all single-cycle operations.
// Shift codes produce zeros here; the iterative shifter lives in the top.
module alu_exec_unit_alu
  import alu_exec_unit_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [FUNC_WIDTH-1:0] func,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  compare_bit,
  output logic                  illegal
);

  logic signed [DATA_WIDTH-1:0] sa, sb, sum, diff, neg;

  assign sa   = a;
  assign sb   = b;
  assign sum  = sa + sb;
  assign diff = sa - sb;
  assign neg  = -sa;

  always_comb begin
    result      = '0;
    overflow    = 1'b0;
    compare_bit = 1'b0;
    illegal     = 1'b0;
    case (func)
      FUNC_SET: result = a;
      FUNC_ADD: begin
        result   = sum;
        overflow = (sa[DATA_WIDTH-1] == sb[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != sa[DATA_WIDTH-1]);
      end
      FUNC_SUB: begin
        result   = diff;
        overflow = (sa[DATA_WIDTH-1] != sb[DATA_WIDTH-1]) && (diff[DATA_WIDTH-1] != sa[DATA_WIDTH-1]);
      end
      FUNC_AND: result = a & b;
      FUNC_OR:  result = a | b;
      FUNC_XOR: result = a ^ b;
      FUNC_NOT: result = ~a;
      FUNC_LSS: begin
        compare_bit = sa < sb;
        result      = {{(DATA_WIDTH-1){1'b0}}, compare_bit};
      end
      FUNC_EQL: begin
        compare_bit = sa == sb;
        result      = {{(DATA_WIDTH-1){1'b0}}, compare_bit};
      end
      FUNC_GRT: begin
        compare_bit = sa > sb;
        result      = {{(DATA_WIDTH-1){1'b0}}, compare_bit};
      end
      // Negating the most negative value wraps back to itself; flag it.
      FUNC_ABS: begin
        result   = sa[DATA_WIDTH-1] ? neg : sa;
        overflow = sa[DATA_WIDTH-1] && neg[DATA_WIDTH-1];
      end
      FUNC_ULS, FUNC_URS, FUNC_SLS, FUNC_SRS: result = '0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked execute-stage responder: single-cycle ALU ops plus bit-serial
// shifts, one request in flight, response held until consumed.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input  logic                  _clk,
  input  logic                  _reset,
  input  logic                  _reqValid,
  output logic                  reqReady,
  input  logic [DATA_WIDTH-1:0] _valA,
  input  logic [DATA_WIDTH-1:0] _valB,
  input  logic [FUNC_WIDTH-1:0] _funcCode,
  output logic                  respValid,
  input  logic                  _respReady,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  compareBit,
  output logic                  illegalFunc
);

  exec_state_t             state;
  logic [FUNC_WIDTH-1:0]   op_p0;
  logic [SHAMT_WIDTH-1:0]  cnt_p0;
  logic [SHAMT_WIDTH-1:0]  amt_in;
  logic [DATA_WIDTH-1:0]   step_p0;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_ovf, alu_cmp, alu_ill;

  function automatic logic [SHAMT_WIDTH-1:0] clamp_count(input logic [DATA_WIDTH-1:0] amt);
    if (amt >= DATA_WIDTH'(DATA_WIDTH)) return SHAMT_WIDTH'(DATA_WIDTH);
    return amt[SHAMT_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_step(input logic [DATA_WIDTH-1:0] v,
                                                       input logic [FUNC_WIDTH-1:0] op);
    logic [DATA_WIDTH-1:0] r;
    case (op)
      FUNC_ULS, FUNC_SLS: r = {v[DATA_WIDTH-2:0], 1'b0};
      FUNC_SRS:           r = {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
      default:            r = {1'b0, v[DATA_WIDTH-1:1]};
    endcase
    return r;
  endfunction

  alu_exec_unit_alu u_alu (
    .a           (_valA),
    .b           (_valB),
    .func        (_funcCode),
    .result      (alu_res),
    .overflow    (alu_ovf),
    .compare_bit (alu_cmp),
    .illegal     (alu_ill)
  );

  assign amt_in    = clamp_count(_valB);
  assign step_p0   = shift_step(result, op_p0);
  assign reqReady  = (state == IDLE);
  assign respValid = (state == DONE);

  // The result register doubles as the shift working register.
  always_ff @(posedge _clk or posedge _reset) begin
    if (_reset) begin
      state       <= IDLE;
      op_p0       <= FUNC_SET;
      cnt_p0      <= '0;
      result      <= '0;
      overflow    <= 1'b0;
      compareBit  <= 1'b0;
      illegalFunc <= 1'b0;
    end else begin
      case (state)
        IDLE: if (_reqValid) begin
          op_p0 <= _funcCode;
          if (is_shift(_funcCode)) begin
            result      <= _valA;
            overflow    <= 1'b0;
            compareBit  <= 1'b0;
            illegalFunc <= 1'b0;
            cnt_p0      <= amt_in;
            state       <= (amt_in == '0) ? DONE : SHIFT;
          end else begin
            result      <= alu_res;
            overflow    <= alu_ovf;
            compareBit  <= alu_cmp;
            illegalFunc <= alu_ill;
            state       <= DONE;
          end
        end
        // One bit per cycle; SLS overflow sticks once the sign bit flips.
        SHIFT: begin
          result <= step_p0;
          cnt_p0 <= cnt_p0 - SHAMT_WIDTH'(1);
          if (op_p0 == FUNC_SLS && step_p0[DATA_WIDTH-1] != result[DATA_WIDTH-1])
            overflow <= 1'b1;
          if (cnt_p0 == SHAMT_WIDTH'(1)) state <= DONE;
        end
        DONE: if (_respReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed table-driven bench for alu_exec_unit with hand-written sequences
// for backpressure and mid-shift reset.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  logic        _clk, _reset, _reqValid, reqReady, respValid, _respReady;
  logic [15:0] _valA, _valB, result;
  logic [3:0]  _funcCode;
  logic        overflow, compareBit, illegalFunc;

  alu_exec_unit dut (
    ._clk        (_clk),
    ._reset      (_reset),
    ._reqValid   (_reqValid),
    .reqReady    (reqReady),
    ._valA       (_valA),
    ._valB       (_valB),
    ._funcCode   (_funcCode),
    .respValid   (respValid),
    ._respReady  (_respReady),
    .result      (result),
    .overflow    (overflow),
    .compareBit  (compareBit),
    .illegalFunc (illegalFunc)
  );

  initial _clk = 1'b0;
  always #5 _clk = ~_clk;

  typedef struct packed {
    logic [3:0]  func;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovf;
    logic        cmp;
    logic        ill;
    logic [7:0]  lat;
  } vec_t;

  vec_t vecs [26];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output bit timeout);
    int w;
    w = 0;
    @(negedge _clk);
    while (!reqReady && w < 60) begin
      @(negedge _clk);
      w++;
    end
    _funcCode = f;
    _valA     = a;
    _valB     = b;
    _reqValid = 1'b1;
    @(posedge _clk);
    lat = 1;
    @(negedge _clk);
    _reqValid = 1'b0;
    _valA     = ~a;
    _valB     = 16'h0000;
    _funcCode = FUNC_ADD;
    while (!respValid && lat < 60) begin
      @(negedge _clk);
      lat++;
    end
    timeout = !respValid;
    if (timeout) begin
      n_err++;
      $display("FAIL timeout: respValid never rose, got 0, expected 1");
    end
  endtask

  task automatic finish_resp(input string name);
    _respReady = 1'b1;
    @(negedge _clk);
    _respReady = 1'b0;
    check({name, " respValid drop"}, respValid, 1'b0);
    check({name, " reqReady back"}, reqReady, 1'b1);
  endtask

  initial begin
    int  lat;
    bit  to;
    vecs = '{
      '{FUNC_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0, 8'd1},
      '{FUNC_SUB, 16'h0021, 16'hFFF3, 16'h002E, 1'b0, 1'b0, 1'b0, 8'd1},
      '{FUNC_SRS, 16'hFFFD, 16'h0004, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd5},
      '{FUNC_ULS, 16'h0002, 16'h0003, 16'h0010, 1'b0, 1'b0, 1'b0, 8'd4},
      '{FUNC_URS, 16'hFFFF, 16'h0014, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd17},
      '{FUNC_LSS, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 8'd1},
      '{FUNC_EQL, 16'hFFF2, 16'hFFF2, 16'h0001, 1'b0, 1'b1, 1'b0, 8'd1},
      '{FUNC_GRT, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd1},
      '{FUNC_ABS, 16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b0, 1'b0, 8'd1},
      '{FUNC_ABS, 16'hFF2C, 16'h0000, 16'h00D4, 1'b0, 1'b0, 1'b0, 8'd1},
      '{4'hF,     16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd1},
      '{FUNC_AND, 16'hABCD, 16'hAAAA, 16'hAA88, 1'b0, 1'b0, 1'b0, 8'd1},
      '{FUNC_SLS, 16'h4000, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0, 8'd2},
      '{FUNC_SLS, 16'hC000, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0, 8'd2},
      '{FUNC_SLS, 16'h4000, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd3},
      '{FUNC_SLS, 16'h0003, 16'h000A, 16'h0C00, 1'b0, 1'b0, 1'b0, 8'd11},
      '{FUNC_SRS, 16'h8000, 16'h0010, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd17},
      '{FUNC_ULS, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 8'd1},
      '{FUNC_SET, 16'h5A5A, 16'h1111, 16'h5A5A, 1'b0, 1'b0, 1'b0, 8'd1},
      '{FUNC_XOR, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 8'd1},
      '{FUNC_NOT, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1'b0, 8'd1},
      '{FUNC_OR,  16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 8'd1},
      '{FUNC_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0, 8'd1},
      '{FUNC_GRT, 16'h0005, 16'hFFFB, 16'h0001, 1'b0, 1'b1, 1'b0, 8'd1},
      '{FUNC_SRS, 16'h4000, 16'h0003, 16'h0800, 1'b0, 1'b0, 1'b0, 8'd4},
      '{FUNC_ADD, 16'h8000, 16'hFFFF, 16'h7FFF, 1'b1, 1'b0, 1'b0, 8'd1}
    };

    _reset = 1'b1; _reqValid = 1'b0; _respReady = 1'b0;
    _valA = 16'h0; _valB = 16'h0; _funcCode = FUNC_SET;
    repeat (2) @(negedge _clk);
    n_vec++;
    check("reset reqReady", reqReady, 1'b1);
    check("reset respValid", respValid, 1'b0);
    check("reset result", result, 16'h0000);
    check("reset flags", {overflow, compareBit, illegalFunc}, 3'b000);
    _reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      run_op(vecs[i].func, vecs[i].a, vecs[i].b, lat, to);
      n_vec++;
      check($sformatf("v%0d result", i), result, vecs[i].res);
      check($sformatf("v%0d overflow", i), overflow, vecs[i].ovf);
      check($sformatf("v%0d compareBit", i), compareBit, vecs[i].cmp);
      check($sformatf("v%0d illegalFunc", i), illegalFunc, vecs[i].ill);
      check($sformatf("v%0d latency", i), lat, {24'd0, vecs[i].lat});
      check($sformatf("v%0d reqReady in DONE", i), reqReady, 1'b0);
      finish_resp($sformatf("v%0d", i));
    end

    // Backpressure: response must hold while the consumer stalls.
    run_op(FUNC_URS, 16'hFFFF, 16'h0002, lat, to);
    n_vec++;
    check("bp latency", lat, 32'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge _clk);
      check($sformatf("bp%0d result", k), result, 16'h3FFF);
      check($sformatf("bp%0d respValid", k), respValid, 1'b1);
      check($sformatf("bp%0d reqReady", k), reqReady, 1'b0);
    end
    finish_resp("bp");

    // Reset in the 4th shift cycle aborts with no response.
    @(negedge _clk);
    _funcCode = FUNC_SLS; _valA = 16'h0003; _valB = 16'h000A; _reqValid = 1'b1;
    @(negedge _clk);
    _reqValid = 1'b0;
    n_vec++;
    check("abort in SHIFT", reqReady, 1'b0);
    repeat (3) @(negedge _clk);
    _reset = 1'b1;
    #1;
    check("abort respValid", respValid, 1'b0);
    check("abort reqReady", reqReady, 1'b1);
    check("abort result", result, 16'h0000);
    @(negedge _clk);
    _reset = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge _clk);
      check($sformatf("abort quiet%0d", k), respValid, 1'b0);
    end
    run_op(FUNC_AND, 16'hABCD, 16'hAAAA, lat, to);
    n_vec++;
    check("post-abort AND result", result, 16'hAA88);
    check("post-abort AND latency", lat, 32'd1);
    finish_resp("post-abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
